// File: rtl/tone_gen_if.sv
// Bundle of the tone generator's request and sample-stream signals.
// The requester drives start/config/hold as master; the generator is slave.
interface tone_gen_if;
    logic               start;
    logic        [3:0]  freq;
    logic signed [15:0] amp;
    logic        [3:0]  nframes;
    logic               hold;
    logic               data_valid;
    logic signed [15:0] data;
    logic               frame_start;
    logic               busy;
    logic               done;

    modport master (
        output start, freq, amp, nframes, hold,
        input  data_valid, data, frame_start, busy, done
    );

    modport slave (
        input  start, freq, amp, nframes, hold,
        output data_valid, data, frame_start, busy, done
    );
endinterface

// File: rtl/tone_gen.sv
// Burst cosine tone generator: emits nframes frames of 16 samples of
// amp * cos(2*pi*k*n/16), with optional idle gap cycles between frames
// and a downstream hold that stalls generation without losing samples.
module tone_gen #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    tone_gen_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FIN} state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t             r_state;
    logic        [3:0]  r_freq;
    logic signed [15:0] r_amp;
    logic        [3:0]  r_nframes;
    logic        [3:0]  r_frame;
    logic        [4:0]  r_n;        // next sample index; 16 marks "frame finished"
    logic        [3:0]  r_gap;
    logic signed [15:0] r_data;
    logic               r_valid;
    logic               r_fs;
    logic               r_done;

    logic               w_last_frame;
    logic signed [15:0] w_sample;
    logic signed [15:0] w_first;

    // Q1.14 cosine table, 16 points per period, symmetric about index 8
    function automatic logic signed [15:0] f_cos(input logic [3:0] idx);
        logic signed [15:0] c;
        case (idx)
            4'd0:          c = 16'sd16384;
            4'd1,  4'd15:  c = 16'sd15137;
            4'd2,  4'd14:  c = 16'sd11585;
            4'd3,  4'd13:  c = 16'sd6270;
            4'd4,  4'd12:  c = 16'sd0;
            4'd5,  4'd11:  c = -16'sd6270;
            4'd6,  4'd10:  c = -16'sd11585;
            4'd7,  4'd9:   c = -16'sd15137;
            default:       c = -16'sd16384;
        endcase
        return c;
    endfunction

    // Clamp a 32-bit signed value into the 16-bit sample range
    function automatic logic signed [15:0] f_sat(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // One sample: (amp * C[(k*n) mod 16]) >>> 14, floor shift, then saturate
    function automatic logic signed [15:0] f_sample(input logic signed [15:0] a,
                                                    input logic [3:0] k,
                                                    input logic [3:0] n);
        logic        [3:0]  idx;
        logic signed [15:0] c;
        logic signed [31:0] a32;
        logic signed [31:0] c32;
        logic signed [31:0] prod;
        idx  = k * n;
        c    = f_cos(idx);
        a32  = {{16{a[15]}}, a};
        c32  = {{16{c[15]}}, c};
        prod = a32 * c32;
        return f_sat(prod >>> 14);
    endfunction

    assign w_last_frame = (r_frame == (r_nframes - 4'd1));
    assign w_sample     = f_sample(r_amp, r_freq, r_n[3:0]);
    assign w_first      = f_sample(bus.amp, bus.freq, 4'd0);

    assign bus.data_valid  = r_valid;
    assign bus.data        = r_data;
    assign bus.frame_start = r_fs;
    assign bus.done        = r_done;
    assign bus.busy        = (r_state != S_IDLE);

    // Burst FSM with registered sample, valid, frame_start and done outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_freq    <= '0;
            r_amp     <= '0;
            r_nframes <= '0;
            r_frame   <= '0;
            r_n       <= '0;
            r_gap     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_fs      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_fs    <= 1'b0;
                    r_data  <= '0;
                    if (bus.start) begin
                        r_freq    <= bus.freq;
                        r_amp     <= bus.amp;
                        r_nframes <= bus.nframes;
                        r_frame   <= '0;
                        r_state   <= S_RUN;
                        // Sample 0 straight from the inputs keeps first-sample latency at one cycle
                        if (!bus.hold) begin
                            r_data  <= w_first;
                            r_valid <= 1'b1;
                            r_fs    <= 1'b1;
                            r_n     <= 5'd1;
                        end else begin
                            r_n <= 5'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_n == 5'd16) begin
                        // Frame complete; hold is irrelevant since nothing is being emitted
                        r_valid <= 1'b0;
                        r_fs    <= 1'b0;
                        r_data  <= '0;
                        r_n     <= 5'd0;
                        if (w_last_frame) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                            r_gap   <= GAP_LOAD;
                            r_frame <= r_frame + 4'd1;
                        end
                    end else if (bus.hold) begin
                        r_valid <= 1'b0;
                        r_fs    <= 1'b0;
                    end else begin
                        r_data  <= w_sample;
                        r_valid <= 1'b1;
                        r_fs    <= (r_n == 5'd0);
                        if (r_n == 5'd15) begin
                            if ((GAP_CYCLES == 0) && !w_last_frame) begin
                                r_n     <= 5'd0;
                                r_frame <= r_frame + 4'd1;
                            end else begin
                                r_n <= 5'd16;
                            end
                        end else begin
                            r_n <= r_n + 5'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_valid <= 1'b0;
                    r_fs    <= 1'b0;
                    r_data  <= '0;
                    if (!bus.hold) begin
                        if (r_gap == 4'd0) begin
                            r_data  <= w_sample;
                            r_valid <= 1'b1;
                            r_fs    <= 1'b1;
                            r_n     <= 5'd1;
                            r_state <= S_RUN;
                        end else begin
                            r_gap <= r_gap - 4'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_valid <= 1'b0;
                    r_fs    <= 1'b0;
                    r_data  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
